// File: rtl/kdf_result_collector.sv
// Result collector for the KDF_spongent UUT: times the UUT run, captures the derived key
// (or a timeout) and streams count + key out as WORD_WIDTH words over valid/ready.
module kdf_result_collector #(
  parameter int          KEY_WIDTH  = 128,
  parameter int          WORD_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uut_rst_i,
  input  logic                  end_i,
  input  logic [KEY_WIDTH-1:0]  key_i,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [WORD_WIDTH-1:0] cycles_o
);

  localparam int NW    = KEY_WIDTH / WORD_WIDTH;
  localparam int IDX_W = $clog2(NW + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NW);
  localparam logic [WORD_WIDTH-1:0] TIMEOUT_W = WORD_WIDTH'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [WORD_WIDTH-1:0] counter;
  logic [KEY_WIDTH-1:0]  key_reg;
  logic [IDX_W-1:0]      idx;
  logic                  done_r;
  logic                  timeout_r;
  logic [WORD_WIDTH-1:0] cycles_r;

  assign word_valid_o = (state == S_SEND);
  assign busy_o       = (state == S_RUN) || (state == S_SEND);
  assign done_o       = done_r;
  assign timeout_o    = timeout_r;
  assign cycles_o     = cycles_r;

  // Word 0 is the latency; the key register shifts left so its top word is always next.
  assign word_o = !word_valid_o     ? '0 :
                  (idx == '0)       ? cycles_r :
                                      key_reg[KEY_WIDTH-1 -: WORD_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      counter   <= '0;
      key_reg   <= '0;
      idx       <= '0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      cycles_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          counter <= '0;
          if (!uut_rst_i) begin
            state     <= S_RUN;
            timeout_r <= 1'b0;
            cycles_r  <= '0;
          end
        end
        S_RUN: begin
          // end_i takes priority over the timeout check on the same cycle.
          if (uut_rst_i) begin
            state <= S_IDLE;
          end else if (end_i) begin
            key_reg  <= key_i;
            cycles_r <= counter;
            idx      <= '0;
            state    <= S_SEND;
          end else if (counter >= TIMEOUT_W) begin
            key_reg   <= '0;
            cycles_r  <= TIMEOUT_W;
            timeout_r <= 1'b1;
            idx       <= '0;
            state     <= S_SEND;
          end else begin
            counter <= counter + WORD_WIDTH'(1);
          end
        end
        S_SEND: begin
          if (uut_rst_i) begin
            state <= S_IDLE;
          end else if (word_ready_i) begin
            if (idx == LAST_IDX) begin
              state  <= S_DONE;
              done_r <= 1'b1;
            end else begin
              if (idx != '0) key_reg <= key_reg << WORD_WIDTH;
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          if (uut_rst_i) begin
            state  <= S_IDLE;
            done_r <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kdf_result_collector.sv
// Directed bench for kdf_result_collector (TIMEOUT=16): latency capture, timeout,
// back-pressure, abort, boundary cases and asynchronous reset.
module tb_kdf_result_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic         uut_rst;
  logic         end_s;
  logic [127:0] key;
  logic [31:0]  word;
  logic         word_valid;
  logic         word_ready;
  logic         busy;
  logic         done;
  logic         timeout;
  logic [31:0]  cycles;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] KEY_A = 128'h00112233445566778899AABBCCDDEEFF;

  logic [31:0] got [5];
  int          ngot;
  logic [31:0] exp_w [5];

  kdf_result_collector #(.KEY_WIDTH(128), .WORD_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .uut_rst_i(uut_rst), .end_i(end_s), .key_i(key),
    .word_o(word), .word_valid_o(word_valid), .word_ready_i(word_ready),
    .busy_o(busy), .done_o(done), .timeout_o(timeout), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leave DONE/IDLE through uut reset and enter RUN with counter 0.
  task automatic start_run;
    end_s   = 1'b0;
    uut_rst = 1'b1;
    tick();
    tick();
    uut_rst = 1'b0;
    tick();
  endtask

  // Gather up to five words with word_ready held high, bounded in cycles.
  task automatic collect;
    ngot = 0;
    word_ready = 1'b1;
    for (int i = 0; i < 40 && ngot < 5; i++) begin
      if (word_valid) begin
        got[ngot] = word;
        ngot++;
      end
      tick();
    end
  endtask

  task automatic set_exp_key(input logic [31:0] w0);
    exp_w[0] = w0;
    exp_w[1] = 32'h00112233;
    exp_w[2] = 32'h44556677;
    exp_w[3] = 32'h8899AABB;
    exp_w[4] = 32'hCCDDEEFF;
  endtask

  task automatic test_reset;
    rst = 1'b1; uut_rst = 1'b1; end_s = 1'b0; key = '0; word_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", word_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL reset_timeout got %b want 0", timeout); end
    n_cmp++; if (cycles !== 32'd0) begin n_bad++; $display("FAIL reset_cycles got %0d want 0", cycles); end
    n_cmp++; if (word !== 32'd0) begin n_bad++; $display("FAIL reset_word got %h want 0", word); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    start_run();
    repeat (5) tick();
    end_s = 1'b1; key = KEY_A;
    tick();
    end_s = 1'b0; key = '0;
    n_cmp++; if (cycles !== 32'd5) begin n_bad++; $display("FAIL basic_cycles got %0d want 5", cycles); end
    n_cmp++; if (word_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", word_valid); end
    set_exp_key(32'd5);
    collect();
    n_cmp++; if (ngot !== 5) begin n_bad++; $display("FAIL basic_count got %0d want 5", ngot); end
    for (int i = 0; i < ngot; i++) begin
      n_cmp++; if (got[i] !== exp_w[i]) begin n_bad++; $display("FAIL basic_word%0d got %h want %h", i, got[i], exp_w[i]); end
    end
    n_cmp++; if (word_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_after got %b want 0", word_valid); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done got %b want 1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy got %b want 0", busy); end
    // end_i in DONE must be ignored and done_o held.
    end_s = 1'b1; key = KEY_A;
    tick(); tick();
    end_s = 1'b0;
    n_cmp++; if (word_valid !== 1'b0 || done !== 1'b1 || cycles !== 32'd5) begin
      n_bad++; $display("FAIL basic_hold got valid=%b done=%b cycles=%0d want 0 1 5", word_valid, done, cycles);
    end
  endtask

  task automatic test_timeout;
    int k;
    start_run();
    key = KEY_A;
    k = 0;
    while (!word_valid && k < 40) begin tick(); k++; end
    n_cmp++; if (k !== 17) begin n_bad++; $display("FAIL to_run_cycles got %0d want 17", k); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL to_flag got %b want 1", timeout); end
    n_cmp++; if (cycles !== 32'd16) begin n_bad++; $display("FAIL to_cycles got %0d want 16", cycles); end
    collect();
    n_cmp++; if (ngot !== 5) begin n_bad++; $display("FAIL to_count got %0d want 5", ngot); end
    for (int i = 0; i < ngot; i++) begin
      n_cmp++;
      if (got[i] !== ((i == 0) ? 32'd16 : 32'd0)) begin
        n_bad++; $display("FAIL to_word%0d got %h want %h", i, got[i], (i == 0) ? 32'd16 : 32'd0);
      end
    end
    n_cmp++; if (done !== 1'b1 || timeout !== 1'b1) begin n_bad++; $display("FAIL to_done got done=%b to=%b want 1 1", done, timeout); end
    key = '0;
  endtask

  task automatic test_back_pressure;
    logic [31:0] hold;
    logic        stalled;
    start_run();
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL bp_timeout_clear got %b want 0", timeout); end
    repeat (5) tick();
    end_s = 1'b1; key = KEY_A;
    tick();
    end_s = 1'b0; key = '0;
    set_exp_key(32'd5);
    ngot = 0;
    for (int c = 0; c < 60 && ngot < 5; c++) begin
      word_ready = (c % 3 == 0);
      stalled = 1'b0;
      hold = word;
      if (word_valid) begin
        if (word_ready) begin got[ngot] = word; ngot++; end
        else stalled = 1'b1;
      end
      tick();
      if (stalled) begin
        n_cmp++;
        if (word_valid !== 1'b1 || word !== hold) begin
          n_bad++; $display("FAIL bp_stable got valid=%b word=%h want 1 %h", word_valid, word, hold);
        end
      end
    end
    word_ready = 1'b0;
    n_cmp++; if (ngot !== 5) begin n_bad++; $display("FAIL bp_count got %0d want 5", ngot); end
    for (int i = 0; i < ngot; i++) begin
      n_cmp++; if (got[i] !== exp_w[i]) begin n_bad++; $display("FAIL bp_word%0d got %h want %h", i, got[i], exp_w[i]); end
    end
    tick();
    n_cmp++; if (done !== 1'b1 || word_valid !== 1'b0) begin n_bad++; $display("FAIL bp_done got done=%b valid=%b want 1 0", done, word_valid); end
  endtask

  task automatic test_abort;
    start_run();
    repeat (5) tick();
    end_s = 1'b1; key = KEY_A;
    tick();
    end_s = 1'b0;
    word_ready = 1'b1;
    tick(); tick();
    uut_rst = 1'b1;
    tick();
    n_cmp++; if (word_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle got valid=%b busy=%b done=%b want 0 0 0", word_valid, busy, done);
    end
    uut_rst = 1'b0;
    tick();
    repeat (3) tick();
    end_s = 1'b1;
    tick();
    end_s = 1'b0; key = '0;
    set_exp_key(32'd3);
    collect();
    n_cmp++; if (ngot !== 5) begin n_bad++; $display("FAIL abort_count got %0d want 5", ngot); end
    for (int i = 0; i < ngot; i++) begin
      n_cmp++; if (got[i] !== exp_w[i]) begin n_bad++; $display("FAIL abort_word%0d got %h want %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_boundaries;
    // end_i on the very first RUN cycle gives latency 0.
    start_run();
    end_s = 1'b1; key = KEY_A;
    tick();
    end_s = 1'b0; key = '0;
    set_exp_key(32'd0);
    collect();
    n_cmp++; if (ngot !== 5) begin n_bad++; $display("FAIL first_count got %0d want 5", ngot); end
    for (int i = 0; i < ngot; i++) begin
      n_cmp++; if (got[i] !== exp_w[i]) begin n_bad++; $display("FAIL first_word%0d got %h want %h", i, got[i], exp_w[i]); end
    end
    // end_i on the cycle the counter reaches TIMEOUT: end wins.
    start_run();
    repeat (16) tick();
    end_s = 1'b1; key = KEY_A;
    tick();
    end_s = 1'b0; key = '0;
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL edge_timeout got %b want 0", timeout); end
    n_cmp++; if (cycles !== 32'd16) begin n_bad++; $display("FAIL edge_cycles got %0d want 16", cycles); end
    set_exp_key(32'd16);
    collect();
    n_cmp++; if (ngot !== 5) begin n_bad++; $display("FAIL edge_count got %0d want 5", ngot); end
    for (int i = 0; i < ngot; i++) begin
      n_cmp++; if (got[i] !== exp_w[i]) begin n_bad++; $display("FAIL edge_word%0d got %h want %h", i, got[i], exp_w[i]); end
    end
  endtask

  task automatic test_async_reset;
    start_run();
    repeat (5) tick();
    end_s = 1'b1; key = KEY_A;
    tick();
    end_s = 1'b0;
    word_ready = 1'b1;
    tick();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (word_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL arst_ctrl got valid=%b busy=%b done=%b want 0 0 0", word_valid, busy, done);
    end
    n_cmp++; if (cycles !== 32'd0 || word !== 32'd0 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL arst_data got cycles=%0d word=%h to=%b want 0 0 0", cycles, word, timeout);
    end
    uut_rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || word_valid !== 1'b0) begin n_bad++; $display("FAIL arst_idle got busy=%b valid=%b want 0 0", busy, word_valid); end
    uut_rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL arst_restart got busy=%b want 1", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_back_pressure();
    test_abort();
    test_boundaries();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
